// File: rtl/cpu_types_pkg.sv
// Basic datapath word and instruction-field types shared across the pipeline.
package cpu_types_pkg;

    localparam int unsigned WordW = 32;

    typedef logic [WordW-1:0] word_t;
    typedef logic [5:0]       opcode_t;
    typedef logic [5:0]       funct_t;
    typedef logic [4:0]       regbits_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath mux selects shared between the fetch stage and the hazard unit.
package data_path_muxs_pkg;

    typedef enum logic [2:0] {
        SEL_LOAD_NXT_INSTR     = 3'd0,
        SEL_LOAD_BR_ADDR       = 3'd1,
        SEL_LOAD_NXT_PC_EX_MEM = 3'd2,
        SEL_LOAD_JMP_ADDR      = 3'd3,
        SEL_LOAD_JR_ADDR       = 3'd4
    } pcsrc_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of every non-clock/reset signal crossing the fetch stage boundary.
interface fetch_stage_if
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) ();

    pcsrc_t               PCSrc;
    logic                 enable_pc;
    logic                 enable_IF_ID;
    logic                 flush_IF_ID;
    logic                 ihit;
    word_t                imemload;
    word_t                restore_pc;
    word_t                jr_addr;
    logic                 halt;
    logic                 imemREN;
    word_t                imemaddr;
    word_t                instr_IF_ID;
    word_t                npc_IF_ID;
    logic                 valid_IF_ID;
    opcode_t              opcode_IF_ID;
    funct_t               func_IF_ID;
    regbits_t             Rs_IF_ID;
    regbits_t             Rt_IF_ID;
    logic [COUNT_W-1:0]   fetch_count;

    modport latch (
        input  enable_IF_ID, flush_IF_ID, ihit, imemload,
        output instr_IF_ID, npc_IF_ID, valid_IF_ID, fetch_count
    );

    modport hazard (
        output PCSrc, enable_pc, enable_IF_ID, flush_IF_ID,
        input  opcode_IF_ID, func_IF_ID, Rs_IF_ID, Rt_IF_ID, valid_IF_ID
    );

endinterface

// File: rtl/if_id_latch.sv
// IF/ID pipeline register with halt/stall/flush priority and the retired-fetch counter.
module if_id_latch
    import cpu_types_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          halted,
    input  word_t         npc,
    fetch_stage_if.latch  bus
);

    word_t              instr_q;
    word_t              npc_q;
    logic               valid_q;
    logic [COUNT_W-1:0] count_q;

    // Halt beats stall, stall beats flush: a flush arriving during a stall is lost.
    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else if (halted) begin
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else if (!bus.enable_IF_ID) begin
            instr_q <= instr_q;
            npc_q   <= npc_q;
            valid_q <= valid_q;
        end else if (bus.flush_IF_ID) begin
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= bus.imemload;
            npc_q   <= npc;
            valid_q <= bus.ihit;
            if (bus.ihit) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    assign bus.instr_IF_ID = instr_q;
    assign bus.npc_IF_ID   = npc_q;
    assign bus.valid_IF_ID = valid_q;
    assign bus.fetch_count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, imem request and IF/ID latch.
module fetch_stage
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;
#(
    parameter word_t       PC_INIT = 32'h0000_0000,
    parameter int unsigned COUNT_W = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  pcsrc_t             PCSrc,
    input  logic               enable_pc,
    input  logic               enable_IF_ID,
    input  logic               flush_IF_ID,
    input  logic               ihit,
    input  word_t              imemload,
    input  word_t              restore_pc,
    input  word_t              jr_addr,
    input  logic               halt,
    output logic               imemREN,
    output word_t              imemaddr,
    output word_t              instr_IF_ID,
    output word_t              npc_IF_ID,
    output logic               valid_IF_ID,
    output opcode_t            opcode_IF_ID,
    output funct_t             func_IF_ID,
    output regbits_t           Rs_IF_ID,
    output regbits_t           Rt_IF_ID,
    output logic [COUNT_W-1:0] fetch_count
);

    fetch_stage_if #(.COUNT_W(COUNT_W)) bus ();

    assign bus.PCSrc        = PCSrc;
    assign bus.enable_pc    = enable_pc;
    assign bus.enable_IF_ID = enable_IF_ID;
    assign bus.flush_IF_ID  = flush_IF_ID;
    assign bus.ihit         = ihit;
    assign bus.imemload     = imemload;
    assign bus.restore_pc   = restore_pc;
    assign bus.jr_addr      = jr_addr;
    assign bus.halt         = halt;

    word_t pc_q;
    word_t pc_plus4;
    word_t br_offset;
    word_t next_pc;
    logic  halted_q;

    assign pc_plus4  = pc_q + 32'd4;
    assign br_offset = {{14{bus.instr_IF_ID[15]}}, bus.instr_IF_ID[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (bus.PCSrc)
            SEL_LOAD_NXT_INSTR:     next_pc = pc_plus4;
            SEL_LOAD_BR_ADDR:       next_pc = bus.npc_IF_ID + br_offset;
            SEL_LOAD_NXT_PC_EX_MEM: next_pc = bus.restore_pc;
            SEL_LOAD_JMP_ADDR:      next_pc = {bus.npc_IF_ID[31:28], bus.instr_IF_ID[25:0], 2'b00};
            SEL_LOAD_JR_ADDR:       next_pc = bus.jr_addr;
            default:                next_pc = pc_plus4;
        endcase
    end

    // enable_pc already folds in memory-hit gating; only halt can still freeze the PC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q     <= PC_INIT;
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_q | bus.halt;
            if (bus.enable_pc && !halted_q) begin
                pc_q <= next_pc;
            end
        end
    end

    if_id_latch #(
        .COUNT_W (COUNT_W)
    ) u_if_id_latch (
        .CLK    (CLK),
        .RST    (RST),
        .halted (halted_q),
        .npc    (pc_plus4),
        .bus    (bus.latch)
    );

    assign bus.imemREN      = ~halted_q;
    assign bus.imemaddr     = pc_q;
    assign bus.opcode_IF_ID = bus.instr_IF_ID[31:26];
    assign bus.func_IF_ID   = bus.instr_IF_ID[5:0];
    assign bus.Rs_IF_ID     = bus.instr_IF_ID[25:21];
    assign bus.Rt_IF_ID     = bus.instr_IF_ID[20:16];

    assign imemREN      = bus.imemREN;
    assign imemaddr     = bus.imemaddr;
    assign instr_IF_ID  = bus.instr_IF_ID;
    assign npc_IF_ID    = bus.npc_IF_ID;
    assign valid_IF_ID  = bus.valid_IF_ID;
    assign opcode_IF_ID = bus.opcode_IF_ID;
    assign func_IF_ID   = bus.func_IF_ID;
    assign Rs_IF_ID     = bus.Rs_IF_ID;
    assign Rt_IF_ID     = bus.Rt_IF_ID;
    assign fetch_count  = bus.fetch_count;

endmodule
